// File: rtl/master_bridge_if.sv
// Command/response and bus signals of master_bridge, bundled with a modport
// for the bridge itself (master) and one for its environment (slave).
interface master_bridge_if;
    // cmd handshake: a command transfers on a rising edge where cmd_valid & cmd_ready;
    // cmd_ready is high only while idle, and cmd_* are don't-care otherwise.
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        wr_done;
    logic        busy;
    logic        master_sel;
    logic        master_enable;
    logic        master_wr_dir;
    logic [15:0] master_addr;
    logic [15:0] master_wdata;
    logic [15:0] master_rdata;
    logic [1:0]  state_dbg;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, master_rdata,
        output cmd_ready, rsp_valid, rsp_data, wr_done, busy,
        output master_sel, master_enable, master_wr_dir, master_addr, master_wdata,
        output state_dbg
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, master_rdata,
        input  cmd_ready, rsp_valid, rsp_data, wr_done, busy,
        input  master_sel, master_enable, master_wr_dir, master_addr, master_wdata,
        input  state_dbg
    );
endinterface

// File: rtl/master_bridge.sv
// Single-command bus master: turns one accepted command into a SETUP/ACCESS
// bus transfer, with RD_LAT wait cycles before read data is captured.
module master_bridge #(
    parameter int unsigned RD_LAT = 3
) (
    input logic            clk,
    input logic            rst,
    master_bridge_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic        en_q, en_d;
    logic        wr_dir_q, wr_dir_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        wr_done_q, wr_done_d;
    logic        accept;

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.cmd_valid) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: state_d = wr_dir_q ? S_IDLE : S_WAIT;
            S_WAIT:   if (cnt_q == 4'd0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values for the output registers, derived from where the FSM is heading.
    always_comb begin
        sel_d       = (state_d != S_IDLE);
        en_d        = (state_d == S_ACCESS) || (state_d == S_WAIT);
        wr_dir_d    = accept ? bus.cmd_wr : ((state_d == S_IDLE) ? 1'b0 : wr_dir_q);
        addr_d      = accept ? bus.cmd_addr  : addr_q;
        wdata_d     = accept ? bus.cmd_wdata : wdata_q;
        cnt_d       = cnt_q;
        if (state_q == S_ACCESS)
            cnt_d = CNT_LOAD;
        else if ((state_q == S_WAIT) && (cnt_q != 4'd0))
            cnt_d = cnt_q - 4'd1;
        wr_done_d   = (state_q == S_ACCESS) && wr_dir_q;
        rsp_valid_d = (state_q == S_WAIT) && (cnt_q == 4'd0);
        rsp_data_d  = rsp_valid_d ? bus.master_rdata : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            wr_dir_q    <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            cnt_q       <= 4'd0;
            rsp_data_q  <= 16'h0000;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            en_q        <= en_d;
            wr_dir_q    <= wr_dir_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign bus.cmd_ready     = (state_q == S_IDLE);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.master_sel    = sel_q;
    assign bus.master_enable = en_q;
    assign bus.master_wr_dir = wr_dir_q;
    assign bus.master_addr   = addr_q;
    assign bus.master_wdata  = wdata_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.wr_done       = wr_done_q;
    assign bus.state_dbg     = state_q;
endmodule

// File: tb/tb_master_bridge.sv
// Bench for master_bridge: a memory-backed interconnect, a transaction-level
// reference model timed in cycles since accept, and a read-data scoreboard.
module tb_master_bridge;
    localparam int RD_LAT = 3;

    logic clk;
    logic rst;
    master_bridge_if bus ();

    master_bridge #(.RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- interconnect: memory with registered read data ----------------
    bit [15:0] smem [65536];
    always @(posedge clk) begin
        if (bus.master_sel && bus.master_enable && bus.master_wr_dir)
            smem[bus.master_addr] <= bus.master_wdata;
        bus.master_rdata <= smem[bus.master_addr];
    end

    // ---------------- reference model ----------------
    bit [15:0]   shadow [65536];
    bit          m_have;
    int          m_k;
    int          m_span;
    bit          m_wr;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rsp;
    logic [15:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge given the inputs present before it.
    task automatic model_edge(input bit r, input bit v, input bit w,
                              input logic [15:0] a, input logic [15:0] d);
        if (m_have && m_wr && m_k == 2) shadow[m_addr] = m_wdata;
        if (r) begin
            m_have = 0; m_k = 0; m_rsp = 16'h0000;
            m_addr = 16'h0000; m_wdata = 16'h0000;
            exp_q.delete();
        end else if (m_have && m_k < m_span) begin
            m_k++;
            if (!m_wr && m_k == m_span) m_rsp = shadow[m_addr];
        end else begin
            m_have = 0;
            if (v) begin
                m_have = 1; m_k = 1; m_wr = w; m_addr = a; m_wdata = d;
                m_span = w ? 3 : RD_LAT + 3;
                if (!w) exp_q.push_back(shadow[a]);
            end
        end
    endtask

    task automatic compare_all();
        bit busy_e;
        busy_e = m_have && (m_k < m_span);
        chk("cmd_ready", bus.cmd_ready, !busy_e);
        chk("busy", bus.busy, busy_e);
        chk("master_sel", bus.master_sel, busy_e);
        chk("master_enable", bus.master_enable, busy_e && m_k >= 2);
        chk("master_wr_dir", bus.master_wr_dir, busy_e && m_wr);
        chk("master_addr", bus.master_addr, m_addr);
        chk("master_wdata", bus.master_wdata, m_wdata);
        chk("wr_done", bus.wr_done, m_have && m_wr && m_k == m_span);
        chk("rsp_valid", bus.rsp_valid, m_have && !m_wr && m_k == m_span);
        chk("rsp_data", bus.rsp_data, m_rsp);
        chk("pulse_excl", bus.rsp_valid & bus.wr_done, 1'b0);
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 1'b1, 1'b0);
            else                   chk("rsp_scoreboard", bus.rsp_data, exp_q.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit v, input bit w,
                        input logic [15:0] a, input logic [15:0] d);
        rst           = r;
        bus.cmd_valid = v;
        bus.cmd_wr    = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        @(posedge clk);
        model_edge(r, v, w, a, d);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0000, 16'h0000);
    endtask

    // Issue one command and run until its completion-pulse cycle.
    task automatic do_txn(input bit w, input logic [15:0] a, input logic [15:0] d);
        step(0, 1, w, a, d);
        idle(w ? 2 : RD_LAT + 2);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] seq_addr [4];
    logic [15:0] seq_data [4];

    initial begin
        int first_rsp;
        int rsp_cnt;
        m_have = 0; m_k = 0; m_span = 0; m_wr = 0;
        m_addr = 16'h0000; m_wdata = 16'h0000; m_rsp = 16'h0000;
        step(1, 0, 0, 16'h0000, 16'h0000);
        step(1, 0, 0, 16'h0000, 16'h0000);
        chk("reset_ready", bus.cmd_ready, 1'b1);
        chk("reset_rsp_data", bus.rsp_data, 16'h0000);

        // Directed write then read-back of the same word.
        do_txn(1, 16'h4005, 16'hBEEF);
        chk("wr_mem", smem[16'h4005], 16'hBEEF);
        first_rsp = 0; rsp_cnt = 0;
        step(0, 1, 0, 16'h4005, 16'h0000);
        for (int i = 2; i <= 9; i++) begin
            step(0, 0, 0, 16'h0000, 16'h0000);
            if (bus.rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (first_rsp == 0) first_rsp = i;
            end
        end
        chk("rd_latency_cycles", 16'(first_rsp), 16'(RD_LAT + 3));
        chk("rd_pulse_width", 16'(rsp_cnt), 16'd1);
        chk("rd_data", bus.rsp_data, 16'hBEEF);

        // One write per slave, read back in reverse order.
        seq_addr[0] = 16'h0000; seq_addr[1] = 16'h4000;
        seq_addr[2] = 16'h8000; seq_addr[3] = 16'hC000;
        seq_data[0] = 16'h1111; seq_data[1] = 16'h2222;
        seq_data[2] = 16'h3333; seq_data[3] = 16'h4444;
        for (int i = 0; i < 4; i++) do_txn(1, seq_addr[i], seq_data[i]);
        for (int i = 3; i >= 0; i--) begin
            do_txn(0, seq_addr[i], 16'h0000);
            chk("seq_rsp", bus.rsp_data, seq_data[i]);
        end

        // cmd_valid held with changing fields while busy.
        for (int i = 0; i < 14; i++)
            step(0, 1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        idle(RD_LAT + 4);

        // Reset during the second WAIT cycle of a read.
        step(0, 1, 0, 16'h8000, 16'h0000);
        idle(3);
        step(1, 0, 0, 16'h0000, 16'h0000);
        chk("abort_sel", bus.master_sel, 1'b0);
        chk("abort_en", bus.master_enable, 1'b0);
        chk("abort_addr", bus.master_addr, 16'h0000);
        chk("abort_rsp_data", bus.rsp_data, 16'h0000);
        chk("abort_ready", bus.cmd_ready, 1'b1);
        idle(RD_LAT + 3);

        // Reset wins over a simultaneous command.
        step(1, 1, 1, 16'h4001, 16'h1234);
        chk("rst_prio_busy", bus.busy, 1'b0);
        step(0, 0, 0, 16'h0000, 16'h0000);
        chk("rst_prio_idle", bus.master_sel, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] a;
            a = {2'($urandom_range(0, 3)), 12'h000, 2'($urandom_range(0, 3))};
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        idle(RD_LAT + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
